// File: rtl/vita_align_pkg.sv
// ---------------------------------------------------------------------------
// vita_align_pkg
// Definitions shared by the VITA LVDS word-alignment logic:
//   - state_t             : alignment controller state encoding
//   - VITA_TRAINING_WORD  : default sensor training pattern (10-bit lanes)
//   - cnt_width()         : bits needed to hold a counter value 0..max_val
// ---------------------------------------------------------------------------
package vita_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    localparam logic [9:0] VITA_TRAINING_WORD = 10'h3A6;

    // Width of a counter that must reach max_val inclusive (at least 1 bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/word_align_ctrl.sv
// ---------------------------------------------------------------------------
// word_align_ctrl
// Per-lane training-word alignment controller. Compares the bitslip muxer's
// parallel output against the latched training word and issues single-cycle
// bitslip pulses until the lane is word aligned, then reports lock and
// (optionally) watches for loss of lock.
//
// Ports:
//   clk           in   clock
//   reset         in   synchronous, active-high reset (shared with the muxer)
//   start         in   begin/restart alignment (accepted in IDLE/LOCKED/FAIL)
//   training_word in   expected pattern, latched on accepted start
//   din           in   word from the bitslip muxer
//   tracking_en   in   enables loss-of-lock monitoring while LOCKED
//   bitslip       out  one-cycle slip pulse to the muxer (high in SLIP)
//   busy          out  high in SETTLE/CHECK/SLIP
//   aligned       out  high only in LOCKED
//   fail          out  high in FAIL
//   lock_lost     out  sticky loss-of-lock flag
//   slip_pos      out  current muxer rotation, modulo DATAWIDTH
// ---------------------------------------------------------------------------
module word_align_ctrl #(
    parameter int DATAWIDTH     = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int MATCH_COUNT   = 16,
    parameter int SLIP_PASSES   = 2,
    parameter int LOSS_COUNT    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] training_word,
    input  logic [DATAWIDTH-1:0] din,
    input  logic                 tracking_en,
    output logic                 bitslip,
    output logic                 busy,
    output logic                 aligned,
    output logic                 fail,
    output logic                 lock_lost,
    output logic [3:0]           slip_pos
);
    import vita_align_pkg::*;

    localparam int MAX_SLIPS = DATAWIDTH * SLIP_PASSES;
    localparam int SETTLE_W  = cnt_width(SETTLE_CYCLES);
    localparam int MATCH_W   = cnt_width(MATCH_COUNT);
    localparam int SLIP_W    = cnt_width(MAX_SLIPS);
    localparam int LOSS_W    = cnt_width(LOSS_COUNT);

    state_t                state, state_next;
    logic [SETTLE_W-1:0]   settle_cnt, settle_next;
    logic [MATCH_W-1:0]    match_cnt, match_next;
    logic [SLIP_W-1:0]     total_slips, slips_next;
    logic [LOSS_W-1:0]     loss_cnt, loss_next;
    logic [DATAWIDTH-1:0]  word, word_next;
    logic [3:0]            pos_next;
    logic                  lost_next;
    logic                  start_ok;
    logic                  word_match;

    // start is only honoured when no alignment sequence is in flight
    assign start_ok   = start && ((state == ST_IDLE) || (state == ST_LOCKED) ||
                                  (state == ST_FAIL));
    assign word_match = (din == word);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            settle_cnt  <= '0;
            match_cnt   <= '0;
            total_slips <= '0;
            loss_cnt    <= '0;
            word        <= '0;
            slip_pos    <= '0;
            lock_lost   <= 1'b0;
            bitslip     <= 1'b0;
            busy        <= 1'b0;
            aligned     <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_next;
            settle_cnt  <= settle_next;
            match_cnt   <= match_next;
            total_slips <= slips_next;
            loss_cnt    <= loss_next;
            word        <= word_next;
            slip_pos    <= pos_next;
            lock_lost   <= lost_next;
            // Outputs are registered from the next state so they line up
            // cycle-for-cycle with the state they describe.
            bitslip     <= (state_next == ST_SLIP);
            busy        <= (state_next == ST_SETTLE) || (state_next == ST_CHECK) ||
                           (state_next == ST_SLIP);
            aligned     <= (state_next == ST_LOCKED);
            fail        <= (state_next == ST_FAIL);
        end
    end

    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        match_next  = match_cnt;
        slips_next  = total_slips;
        loss_next   = loss_cnt;
        word_next   = word;
        pos_next    = slip_pos;
        lost_next   = lock_lost;

        if (start_ok) begin
            // Restart wins over a coincident loss-of-lock in LOCKED.
            // slip_pos is kept: the muxer keeps its rotation across restarts.
            state_next  = ST_SETTLE;
            word_next   = training_word;
            settle_next = '0;
            match_next  = '0;
            slips_next  = '0;
            loss_next   = '0;
            lost_next   = 1'b0;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state_next  = ST_CHECK;
                        settle_next = '0;
                        match_next  = '0;
                    end else begin
                        settle_next = settle_cnt + SETTLE_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (word_match) begin
                        if (match_cnt == MATCH_W'(MATCH_COUNT - 1)) begin
                            state_next = ST_LOCKED;
                            match_next = '0;
                            loss_next  = '0;
                        end else begin
                            match_next = match_cnt + MATCH_W'(1);
                        end
                    end else if (total_slips == SLIP_W'(MAX_SLIPS)) begin
                        state_next = ST_FAIL;
                    end else begin
                        state_next = ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    state_next  = ST_SETTLE;
                    settle_next = '0;
                    slips_next  = total_slips + SLIP_W'(1);
                    pos_next    = (slip_pos == 4'(DATAWIDTH - 1)) ? 4'd0
                                                                  : slip_pos + 4'd1;
                end
                ST_LOCKED: begin
                    if (!tracking_en || word_match) begin
                        loss_next = '0;
                    end else if (loss_cnt == LOSS_W'(LOSS_COUNT - 1)) begin
                        state_next = ST_IDLE;
                        loss_next  = '0;
                        lost_next  = 1'b1;
                    end else begin
                        loss_next = loss_cnt + LOSS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_word_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_word_align_ctrl
// Drives word_align_ctrl from a bitslip-muxer model fed with the VITA
// training stream. Stimulus pushes expected events (slip, lock, fail,
// lock-lost) computed from the alignment rules into a queue; a monitor pops
// and compares whenever the DUT presents one of those events.
// ---------------------------------------------------------------------------
module tb_word_align_ctrl;
    import vita_align_pkg::*;

    localparam int W  = 10;
    localparam int SC = 4;
    localparam int MC = 16;
    localparam int SP = 2;
    localparam int LC = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] training_word = VITA_TRAINING_WORD;
    logic [W-1:0] din;
    logic         tracking_en = 1'b0;
    logic         bitslip, busy, aligned, fail, lock_lost;
    logic [3:0]   slip_pos;

    always #5 clk = ~clk;

    word_align_ctrl #(
        .DATAWIDTH(W), .SETTLE_CYCLES(SC), .MATCH_COUNT(MC),
        .SLIP_PASSES(SP), .LOSS_COUNT(LC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .training_word(training_word),
        .din(din), .tracking_en(tracking_en), .bitslip(bitslip), .busy(busy),
        .aligned(aligned), .fail(fail), .lock_lost(lock_lost), .slip_pos(slip_pos)
    );

    // ---------------- bitslip muxer model (2-cycle sel-to-dout latency)
    int   sel_q = 0, sel_d = 0;
    int   offset = 0;       // number of slips needed from sel=0 to align
    logic pat_zero = 1'b0;  // constant all-zero stream
    logic corrupt = 1'b0;   // force a bad word

    function automatic logic [W-1:0] rotl(input logic [W-1:0] w, input int n);
        logic [W-1:0] r = w;
        for (int i = 0; i < n; i++) r = {r[W-2:0], r[W-1]};
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            sel_q <= 0;
            sel_d <= 0;
        end else begin
            if (bitslip) sel_q <= (sel_q + 1) % W;
            sel_d <= sel_q;
        end
    end

    assign din = pat_zero ? '0 :
                 corrupt  ? ~VITA_TRAINING_WORD :
                 rotl(VITA_TRAINING_WORD, (offset + W - sel_d) % W);

    // ---------------- scoreboard
    typedef enum int {EV_SLIP, EV_LOCK, EV_FAIL, EV_LOST} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       pos;
    } ev_t;

    ev_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  model_pos = 0;   // reference view of the muxer rotation

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk positions from the current one; an aligned position
    // locks (unless the one-shot corruption hits it), a misaligned one
    // either slips or, after W*SP slips, fails.
    task automatic predict(input int off, input bit zero_pat, input bit corrupt_once);
        int p = model_pos;
        int s = 0;
        bit c = corrupt_once;
        ev_t e;
        while (1) begin
            if (!zero_pat && p == off) begin
                if (!c) begin
                    e.kind = EV_LOCK; e.pos = p; sb.push_back(e);
                    break;
                end
                c = 0;
            end
            if (s == W * SP) begin
                e.kind = EV_FAIL; e.pos = p; sb.push_back(e);
                break;
            end
            e.kind = EV_SLIP; e.pos = p; sb.push_back(e);
            p = (p + 1) % W;
            s++;
        end
        model_pos = p;
    endtask

    task automatic check_ev(input ev_kind_t k);
        ev_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d at pos %0d, expected none",
                     int'(k), slip_pos);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.pos != int'(slip_pos)) begin
                fails++;
                $display("FAIL event: got kind %0d pos %0d expected kind %0d pos %0d",
                         int'(k), slip_pos, int'(e.kind), e.pos);
            end
        end
    endtask

    // ---------------- monitor
    initial begin
        logic p_slip = 0, p_al = 0, p_fail = 0, p_lost = 0;
        int   cyc = 0, last_slip = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (start && !busy) last_slip = -1;
                if (bitslip === 1'b1 && !p_slip) begin
                    check_ev(EV_SLIP);
                    if (last_slip >= 0) chk("slip_spacing_ok", int'(cyc - last_slip >= SC + 1), 1);
                    last_slip = cyc;
                end
                if (aligned === 1'b1 && !p_al)     check_ev(EV_LOCK);
                if (fail === 1'b1 && !p_fail)      check_ev(EV_FAIL);
                if (lock_lost === 1'b1 && !p_lost) check_ev(EV_LOST);
            end else begin
                last_slip = -1;
            end
            p_slip = (bitslip === 1'b1);
            p_al   = (aligned === 1'b1);
            p_fail = (fail === 1'b1);
            p_lost = (lock_lost === 1'b1);
        end
    end

    // ---------------- stimulus helpers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        sb.delete();
        model_pos = 0;
    endtask

    task automatic wait_empty(input string name, input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d pending events expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_slips(input int n, input int bound);
        int seen = 0, c = 0;
        while (seen < n && c < bound) begin
            @(negedge clk);
            c++;
            if (bitslip === 1'b1) seen++;
        end
        if (seen < n) begin
            tests++;
            fails++;
            $display("FAIL wait_slips_timeout: got %0d pulses expected %0d", seen, n);
        end
    endtask

    // ---------------- watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus
    initial begin
        int busy_cnt, lat;

        do_reset();
        chk("rst_bitslip", bitslip, 0);
        chk("rst_busy", busy, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_fail", fail, 0);
        chk("rst_lock_lost", lock_lost, 0);
        chk("rst_slip_pos", slip_pos, 0);

        // Aligned lane: latency and busy window; a start while busy is ignored.
        offset = 0;
        predict(0, 0, 0);
        pulse_start();
        busy_cnt = busy ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
            if (busy) busy_cnt++;
            if (aligned && lat < 0) lat = k;
        end
        chk("lock_latency", lat, SC + MC);
        chk("busy_cycles", busy_cnt, SC + MC);
        wait_empty("aligned_lane", 50);

        // Misaligned by 3 from LOCKED.
        offset = 3;
        predict(3, 0, 0);
        pulse_start();
        wait_empty("offset3", 500);
        chk("off3_aligned", aligned, 1);
        chk("off3_fail", fail, 0);
        chk("off3_slip_pos", slip_pos, 3);

        // Offset 3 from reset with a corrupted 10th match on the aligned try.
        do_reset();
        offset = 3;
        predict(3, 0, 1);
        pulse_start();
        wait_slips(3, 200);
        repeat (14) @(posedge clk);
        #1 corrupt = 1'b1;
        @(posedge clk);
        #1 corrupt = 1'b0;
        wait_empty("corrupt", 2000);
        chk("corrupt_aligned", aligned, 1);
        chk("corrupt_slip_pos", slip_pos, 3);

        // Tracking: 7 bad words keep lock, 8 lose it.
        tracking_en = 1'b1;
        corrupt = 1'b1;
        tick(LC - 1);
        corrupt = 1'b0;
        tick(2);
        chk("track7_aligned", aligned, 1);
        chk("track7_lock_lost", lock_lost, 0);
        begin
            ev_t e;
            e.kind = EV_LOST; e.pos = model_pos; sb.push_back(e);
        end
        corrupt = 1'b1;
        tick(LC);
        corrupt = 1'b0;
        chk("track8_aligned", aligned, 0);
        chk("track8_lock_lost", lock_lost, 1);
        chk("track8_busy", busy, 0);
        wait_empty("lost", 20);
        predict(offset, 0, 0);
        pulse_start();
        chk("restart_clears_lost", lock_lost, 0);
        chk("restart_busy", busy, 1);
        wait_empty("relock", 200);

        // start coincident with the last allowed mismatch: restart wins.
        predict(offset, 0, 0);
        corrupt = 1'b1;
        tick(LC - 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        corrupt = 1'b0;
        chk("race_lock_lost", lock_lost, 0);
        chk("race_busy", busy, 1);
        wait_empty("race", 200);
        tracking_en = 1'b0;

        // Randomized offsets and idle gaps.
        for (int i = 0; i < 6; i++) begin
            offset = $urandom_range(0, W - 1);
            tick($urandom_range(1, 5));
            predict(offset, 0, 0);
            pulse_start();
            wait_empty("random", 1000);
            chk("rand_aligned", aligned, 1);
            chk("rand_slip_pos", slip_pos, offset);
        end

        // Constant zero stream from position 0: 20 slips then FAIL.
        do_reset();
        pat_zero = 1'b1;
        predict(0, 1, 0);
        pulse_start();
        wait_empty("zero", 3000);
        chk("zero_fail", fail, 1);
        chk("zero_busy", busy, 0);
        chk("zero_aligned", aligned, 0);
        chk("zero_slip_pos", slip_pos, 0);
        pat_zero = 1'b0;
        offset = (model_pos + 1) % W;
        predict(offset, 0, 0);
        pulse_start();
        chk("fail_restart_busy", busy, 1);
        chk("fail_restart_fail", fail, 0);
        wait_empty("fail_restart", 500);
        chk("fail_restart_aligned", aligned, 1);

        // Reset in the middle of SETTLE after the first slip.
        offset = (model_pos + 2) % W;
        predict(offset, 0, 0);
        pulse_start();
        wait_slips(1, 100);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_bitslip", bitslip, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_aligned", aligned, 0);
        chk("midrst_fail", fail, 0);
        chk("midrst_lock_lost", lock_lost, 0);
        chk("midrst_slip_pos", slip_pos, 0);
        reset = 1'b0;
        sb.delete();
        model_pos = 0;
        tick(1);
        predict(offset, 0, 0);
        pulse_start();
        wait_empty("post_reset", 500);
        chk("post_reset_slip_pos", slip_pos, offset);

        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/word_align_ctrl.md
Name: word_align_ctrl

Overview:
Training-word alignment controller for the VITA LVDS receive path. It sits directly downstream of the per-lane bitslip muxer and consumes that muxer's parallel output word. It compares the word against the sensor training pattern and returns single-cycle bitslip pulses to the muxer until the lane is word-aligned. It then reports lock and optionally monitors for loss of lock.

Parameters:
DATAWIDTH, 10, deserialized word width (4, 8 or 10).
SETTLE_CYCLES, 4, wait after each bitslip before comparing; must be >=2 because of the muxer's sel-to-dout latency.
MATCH_COUNT, 16, consecutive matches required to declare lock.
SLIP_PASSES, 2, number of full rotations (DATAWIDTH slips each) tried before failing.
LOSS_COUNT, 8, consecutive mismatches in LOCKED (with tracking_en) that declare lock lost.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin or restart alignment; sampled every edge
training_word  in  DATAWIDTH  expected pattern; latched on accepted start
din  in  DATAWIDTH  word from the bitslip muxer output
tracking_en  in  1  enables loss-of-lock monitoring in LOCKED
bitslip  out  1  one-cycle pulse to the muxer
busy  out  1  high in SETTLE/CHECK/SLIP
aligned  out  1  high only in LOCKED
fail  out  1  high in FAIL
lock_lost  out  1  sticky; cleared by accepted start or reset
slip_pos  out  4  current muxer rotation, modulo DATAWIDTH

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; latched word 0.
- All outputs are registered and decoded from state. bitslip=1 exactly during SLIP.
- Start acceptance: start is accepted in IDLE, LOCKED and FAIL. It is ignored while busy.
- On accepted start: latch training_word; clear the total-slip counter, match counter and lock_lost; go to SETTLE. slip_pos is NOT cleared, because the muxer position persists across restarts. Only reset clears slip_pos, and reset is shared with the muxer.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, then goes to CHECK with match_cnt=0.
- CHECK: on each edge compare din with the latched word.
  - Match: match_cnt+1. On the MATCH_COUNT-th consecutive match, go to LOCKED.
  - Mismatch: if total_slips == DATAWIDTH*SLIP_PASSES, go to FAIL. Otherwise go to SLIP.
- SLIP: lasts one cycle with bitslip=1. total_slips+1. slip_pos+1, wrapping DATAWIDTH-1 to 0. Then go to SETTLE.
- LOCKED:
  - If tracking_en=1: count consecutive mismatches, resetting the count on any match. When the count reaches LOSS_COUNT: set lock_lost=1, aligned falls, go to IDLE.
  - If tracking_en=0: the loss counter is held at 0.
- FAIL: fail=1 and busy=0; held until accepted start or reset.
- Latency with an already-aligned lane: aligned rises exactly SETTLE_CYCLES+MATCH_COUNT edges after the edge that samples start.
- Cost of each failed position: (cycles spent in CHECK) + 1 + SETTLE_CYCLES.
- Simultaneous events:
  - start in LOCKED in the same cycle as the LOSS_COUNT-th mismatch: start wins (restart), and lock_lost stays 0.
  - reset overrides everything, including mid-SLIP; bitslip is 0 on the following cycle.
- The maximum total_slips of DATAWIDTH*SLIP_PASSES must fit its counter (counter width 5 for the defaults; size it from the parameters).

Decomposition:
- Shared package vita_align_pkg holds:
  - the state encoding (IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL);
  - the default VITA training word constant 10'h3A6;
  - a width function for the counters.
- No sub-module: one FSM plus counters in a single module. One instance per LVDS lane, placed beside each bitslip muxer instance.

Test Plan:
- Muxer model fed the 10'h3A6 stream misaligned by 3 bits, start pulse -> exactly 3 bitslip pulses, each separated by >= SETTLE_CYCLES+1 cycles; aligned=1; slip_pos=3; fail=0.
- Stream already aligned, start -> no bitslip; aligned rises 20 edges after the start edge; busy is high for those 20 cycles.
- Constant 10'h000 stream -> exactly 20 bitslip pulses, then fail=1, busy=0, aligned=0; slip_pos=0 (wrapped twice); a second start restarts from SETTLE.
- Correct alignment at offset 3, one corrupted word at the 10th match -> one slip; lock is reached again after a further 9 slips; slip_pos wraps to 3; aligned=1.
- LOCKED with tracking_en=1: 7 bad words then a good one -> aligned stays 1. 8 consecutive bad words -> aligned=0, lock_lost=1, state IDLE. Next start clears lock_lost.
- Reset asserted mid-SETTLE, and start pulsed while busy -> after reset all outputs 0 and slip_pos=0; the start during busy causes no restart and no extra slip.
